// File: rtl/tof_cmd_dispatch.sv
// tof_cmd_dispatch: command front-end between the Zynq command register and the
// per-sensor ToF FSMs. It detects each new software command, checks it, issues a
// req/ack handshake to the targeted sensors and keeps a 2-bit status per sensor.
module tof_cmd_dispatch #(
    parameter int N_SENSORS   = 8,
    parameter int ACK_TIMEOUT = 1024,
    parameter int TMO_W       = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            ToF_CMD_in,
    output logic [2*N_SENSORS-1:0] ToF_CMD_out,
    output logic [N_SENSORS-1:0]   fsm_req,
    output logic [3:0]             fsm_op,
    input  logic [N_SENSORS-1:0]   fsm_ack,
    input  logic [N_SENSORS-1:0]   fsm_done,
    input  logic [N_SENSORS-1:0]   fsm_err,
    output logic                   cmd_rejected,
    output logic                   dispatch_busy
);

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_DONE = 2'b01;
    localparam logic [1:0] ST_BUSY = 2'b10;
    localparam logic [1:0] ST_ERR  = 2'b11;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(ACK_TIMEOUT - 1);

    state_t                   state_q, state_d;
    logic [31:0]              cmd_q, cmd_d;
    logic                     arm_q, arm_d;
    logic [N_SENSORS-1:0]     req_q, req_d;
    logic [3:0]               op_q, op_d;
    logic [2*N_SENSORS-1:0]   status_q, status_d;
    logic [TMO_W-1:0]         tmo_q, tmo_d;
    logic                     rej_q, rej_d;

    logic [3:0]               cmd_op;
    logic [2:0]               cmd_idx;
    logic                     cmd_bcast;
    logic [N_SENSORS-1:0]     target_mask;
    logic [N_SENSORS-1:0]     busy_vec;
    logic [N_SENSORS-1:0]     req_next;
    logic                     new_cmd;
    logic                     op_legal;
    logic                     target_busy;
    logic                     reject_now;
    logic                     accept_now;
    logic                     unused_cmd_bits;

    assign cmd_op    = cmd_q[3:0];
    assign cmd_idx   = cmd_q[10:8];
    assign cmd_bcast = cmd_q[15];

    // Fields of the command word that carry no meaning for the dispatcher.
    assign unused_cmd_bits = ^{cmd_q[31:16], cmd_q[14:11], cmd_q[7:4]};

    // Decode the registered command: target mask, opcode legality, busy targets.
    always_comb begin
        target_mask = '0;
        busy_vec    = '0;
        op_legal    = 1'b0;
        if (cmd_bcast) begin
            target_mask = '1;
        end else begin
            for (int i = 0; i < N_SENSORS; i++) begin
                if (cmd_idx == 3'(i)) begin
                    target_mask[i] = 1'b1;
                end
            end
        end
        for (int i = 0; i < N_SENSORS; i++) begin
            busy_vec[i] = (status_q[2*i +: 2] == ST_BUSY);
        end
        case (cmd_op)
            4'd1, 4'd2, 4'd3, 4'd5: op_legal = 1'b1;
            default:                op_legal = 1'b0;
        endcase
    end

    assign new_cmd     = arm_q && (cmd_op != 4'd0);
    assign target_busy = |(target_mask & busy_vec);
    assign reject_now  = new_cmd && (!op_legal || target_busy || (state_q != IDLE));
    assign accept_now  = new_cmd && !reject_now;
    assign req_next    = req_q & ~fsm_ack;

    // Next-state logic: arming, completion tracking, handshake and command handling.
    always_comb begin
        state_d  = state_q;
        cmd_d    = ToF_CMD_in;
        arm_d    = arm_q;
        req_d    = req_q;
        op_d     = op_q;
        status_d = status_q;
        tmo_d    = tmo_q;
        rej_d    = 1'b0;

        if (cmd_op == 4'd0) begin
            arm_d = 1'b1;
        end else if (arm_q) begin
            arm_d = 1'b0;
        end

        for (int i = 0; i < N_SENSORS; i++) begin
            if (status_q[2*i +: 2] == ST_BUSY) begin
                if (fsm_err[i]) begin
                    status_d[2*i +: 2] = ST_ERR;
                end else if (fsm_done[i]) begin
                    status_d[2*i +: 2] = ST_DONE;
                end
            end
        end

        case (state_q)
            IDLE: begin
                if (accept_now) begin
                    req_d   = target_mask;
                    op_d    = cmd_op;
                    tmo_d   = '0;
                    state_d = WAIT_ACK;
                    for (int i = 0; i < N_SENSORS; i++) begin
                        if (target_mask[i]) begin
                            status_d[2*i +: 2] = ST_BUSY;
                        end
                    end
                end
            end
            WAIT_ACK: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (req_next == '0) begin
                    req_d   = '0;
                    op_d    = 4'd0;
                    state_d = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    for (int i = 0; i < N_SENSORS; i++) begin
                        if (req_next[i]) begin
                            status_d[2*i +: 2] = ST_ERR;
                        end
                    end
                    req_d   = '0;
                    op_d    = 4'd0;
                    state_d = IDLE;
                end else begin
                    req_d = req_next;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (reject_now) begin
            rej_d = 1'b1;
            if (!op_legal) begin
                for (int i = 0; i < N_SENSORS; i++) begin
                    if (target_mask[i]) begin
                        status_d[2*i +: 2] = ST_ERR;
                    end
                end
            end
        end
    end

    // State register with synchronous reset; a reset forgets any in-flight dispatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cmd_q    <= '0;
            arm_q    <= 1'b1;
            req_q    <= '0;
            op_q     <= 4'd0;
            status_q <= {N_SENSORS{ST_IDLE}};
            tmo_q    <= '0;
            rej_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            arm_q    <= arm_d;
            req_q    <= req_d;
            op_q     <= op_d;
            status_q <= status_d;
            tmo_q    <= tmo_d;
            rej_q    <= rej_d;
        end
    end

    assign ToF_CMD_out   = status_q;
    assign fsm_req       = req_q;
    assign fsm_op        = op_q;
    assign cmd_rejected  = rej_q;
    assign dispatch_busy = (state_q != IDLE);

endmodule
